// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn request channel between the spawn scheduler (master) and the sprite logic (slave).
// valid/ready handshake; slot and lane are held stable while valid waits for ready.
interface enemy_spawn_scheduler_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_slot;
  logic [2:0] spawn_lane;

  modport master (
    output spawn_valid,
    output spawn_slot,
    output spawn_lane,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid,
    input  spawn_slot,
    input  spawn_lane,
    output spawn_ready
  );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// Per-stage enemy spawn sequencer: owns the enemy slots, issues spawn requests on an
// interval, and accumulates the game's kill count.
module enemy_spawn_scheduler #(
  parameter int unsigned NUM_SLOTS      = 2,
  parameter int unsigned SPAWN_INTERVAL = 50,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic [3:0]           i_stage,
  input  logic [NUM_SLOTS-1:0] i_kill_hit,
  output logic [NUM_SLOTS-1:0] o_slot_active,
  output logic [3:0]           o_kills,
  enemy_spawn_scheduler_if.master spawn
);

  localparam logic [7:0] IntervalLd = 8'(SPAWN_INTERVAL);

  typedef enum logic [1:0] {StIdle, StWait, StReq, StDone} state_e;

  state_e               r_state;
  logic [3:0]           r_stage_q;
  logic [7:0]           r_cnt;
  logic [7:0]           r_lfsr;
  logic [1:0]           r_spawned;
  logic [NUM_SLOTS-1:0] r_slot_active;
  logic [3:0]           r_kills;
  logic                 r_valid;
  logic [1:0]           r_slot;
  logic [2:0]           r_lane;

  logic                 w_stage_chg;
  logic                 w_combat;
  logic [1:0]           w_quota;
  logic                 w_free_any;
  logic [1:0]           w_free_idx;
  logic [NUM_SLOTS-1:0] w_kill_mask;
  logic [NUM_SLOTS-1:0] w_slot_onehot;
  logic [2:0]           w_kill_cnt;
  logic [4:0]           w_kills_sum;
  logic [3:0]           w_kills_nxt;
  logic                 w_lfsr_fb;

  function automatic logic [1:0] stage_quota(input logic [3:0] s);
    if (s >= 4'd1 && s <= 4'd4) return 2'd2;
    else if (s == 4'd5)         return 2'd1;
    else                        return 2'd0;
  endfunction

  assign w_stage_chg = (i_stage != r_stage_q);
  assign w_combat    = (i_stage >= 4'd1) && (i_stage <= 4'd5);
  assign w_quota     = stage_quota(r_stage_q);
  assign w_kill_mask = i_kill_hit & r_slot_active;
  assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_free_any    = 1'b0;
    w_free_idx    = 2'd0;
    w_kill_cnt    = 3'd0;
    w_slot_onehot = '0;
    // Descending scan so the lowest free index wins.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = 2'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_kill_cnt       = w_kill_cnt + {2'b00, w_kill_mask[i]};
      w_slot_onehot[i] = (r_slot == 2'(i));
    end
    w_kills_sum = {1'b0, r_kills} + {2'b00, w_kill_cnt};
    w_kills_nxt = (w_kills_sum > 5'd15) ? 4'hF : w_kills_sum[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_stage_q     <= 4'd0;
      r_cnt         <= IntervalLd;
      r_lfsr        <= LFSR_SEED;
      r_spawned     <= 2'd0;
      r_slot_active <= '0;
      r_kills       <= 4'd0;
      r_valid       <= 1'b0;
      r_slot        <= 2'd0;
      r_lane        <= 3'd0;
    end else begin
      r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
      r_stage_q <= i_stage;

      if (i_stage == 4'd0)  r_kills <= 4'd0;
      else if (!w_stage_chg) r_kills <= w_kills_nxt;

      if (w_stage_chg) begin
        // A stage change aborts everything, including a pending handshake.
        r_slot_active <= '0;
        r_valid       <= 1'b0;
        r_spawned     <= 2'd0;
        r_cnt         <= IntervalLd;
        r_state       <= w_combat ? StWait : StIdle;
      end else begin
        r_slot_active <= r_slot_active & ~w_kill_mask;
        unique case (r_state)
          StWait: begin
            if (i_tick && (r_cnt != 8'd0)) r_cnt <= r_cnt - 8'd1;
            if ((r_cnt == 8'd0) && (r_spawned < w_quota) && w_free_any) begin
              r_state <= StReq;
              r_valid <= 1'b1;
              r_slot  <= w_free_idx;
              r_lane  <= r_lfsr[2:0];
            end
          end
          StReq: begin
            if (spawn.spawn_ready) begin
              r_slot_active <= (r_slot_active & ~w_kill_mask) | w_slot_onehot;
              r_valid       <= 1'b0;
              r_spawned     <= r_spawned + 2'd1;
              r_cnt         <= IntervalLd;
              r_state       <= ((r_spawned + 2'd1) == w_quota) ? StDone : StWait;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spawn.spawn_valid = r_valid;
  assign spawn.spawn_slot  = r_slot;
  assign spawn.spawn_lane  = r_lane;
  assign o_slot_active     = r_slot_active;
  assign o_kills           = r_kills;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Scenario bench for enemy_spawn_scheduler: a two-slot instance driven through whole games
// with a spawn scoreboard, plus a one-slot instance for the all-slots-busy case.
module tb_enemy_spawn_scheduler;

  localparam int unsigned Interval = 50;
  localparam logic [7:0]  Seed     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] stage;
  logic [1:0] kill_hit;
  logic [1:0] slot_active;
  logic [3:0] kills;
  logic [3:0] stage1;
  logic [0:0] kill_hit1;
  logic [0:0] slot_active1;
  logic [3:0] kills1;

  enemy_spawn_scheduler_if bus0 ();
  enemy_spawn_scheduler_if bus1 ();

  enemy_spawn_scheduler #(
    .NUM_SLOTS      (2),
    .SPAWN_INTERVAL (Interval),
    .LFSR_SEED      (Seed)
  ) dut0 (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (tick),
    .i_stage       (stage),
    .i_kill_hit    (kill_hit),
    .o_slot_active (slot_active),
    .o_kills       (kills),
    .spawn         (bus0.master)
  );

  enemy_spawn_scheduler #(
    .NUM_SLOTS      (1),
    .SPAWN_INTERVAL (4),
    .LFSR_SEED      (8'h3C)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (tick),
    .i_stage       (stage1),
    .i_kill_hit    (kill_hit1),
    .o_slot_active (slot_active1),
    .o_kills       (kills1),
    .spawn         (bus1.master)
  );

  always #5 clk = ~clk;

  // Reference lane LFSR; m_prev is the value seen at the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= Seed;
      m_prev <= Seed;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         phase = 0;
  int         ticks_since = 0;
  int         tick_age = 0;
  logic [3:0] tb_stage_q = 4'd0;
  logic       prev_valid = 1'b0;
  logic       auto_kill = 1'b0;
  logic [2:0] last_exp_lane = 3'd0;
  logic [1:0] exp_q[$];

  task automatic monitor();
    logic [1:0] exp_slot;
    if (bus0.spawn_valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_spawn slot=%0d required=no_request", bus0.spawn_slot);
      end else begin
        exp_slot      = exp_q.pop_front();
        last_exp_lane = m_prev[2:0];
        if (bus0.spawn_slot !== exp_slot) begin
          errors++;
          $display("FAIL spawn_slot got=%0d required=%0d", bus0.spawn_slot, exp_slot);
        end
        checks++;
        if (bus0.spawn_lane !== last_exp_lane) begin
          errors++;
          $display("FAIL spawn_lane got=%0d required=%0d", bus0.spawn_lane, last_exp_lane);
        end
        checks++;
        if (ticks_since != Interval || tick_age != 1) begin
          errors++;
          $display("FAIL spawn_latency ticks=%0d age=%0d required ticks=%0d age=1",
                   ticks_since, tick_age, Interval);
        end
      end
    end
    prev_valid = bus0.spawn_valid;
  endtask

  // One clock: inputs applied before the edge, outputs sampled at the following negedge.
  task automatic step();
    logic       hs;
    logic       chg;
    logic [1:0] hs_slot;
    tick    = (phase == 3);
    hs      = bus0.spawn_valid && bus0.spawn_ready;
    hs_slot = bus0.spawn_slot;
    chg     = (stage != tb_stage_q);
    @(posedge clk);
    tb_stage_q = stage;
    phase      = (phase + 1) % 4;
    if (hs || chg)                     ticks_since = 0;
    else if (tick && ticks_since < 1000) ticks_since++;
    tick_age = tick ? 0 : tick_age + 1;
    @(negedge clk);
    kill_hit  = '0;
    kill_hit1 = '0;
    if (auto_kill && hs) kill_hit[hs_slot] = 1'b1;
    monitor();
  endtask

  task automatic set_stage(input logic [3:0] s);
    stage = s;
    phase = 0;
    step();
  endtask

  task automatic run_until_empty(input int bound, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic play_stage(input logic [3:0] s, input int n, input int tail);
    for (int i = 0; i < n; i++) exp_q.push_back(2'd0);
    set_stage(s);
    run_until_empty(600, "play_stage");
    repeat (tail) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick = 1'b0;
    stage = 4'd0;
    stage1 = 4'd0;
    kill_hit = '0;
    kill_hit1 = '0;
    bus0.spawn_ready = 1'b0;
    bus1.spawn_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus0.spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", bus0.spawn_valid); end
    if (bus0.spawn_slot !== 2'd0) begin errors++; $display("FAIL reset_slot got=%0d required=0", bus0.spawn_slot); end
    if (bus0.spawn_lane !== 3'd0) begin errors++; $display("FAIL reset_lane got=%0d required=0", bus0.spawn_lane); end
    if (slot_active !== 2'b00) begin errors++; $display("FAIL reset_active got=%b required=00", slot_active); end
    if (kills !== 4'd0) begin errors++; $display("FAIL reset_kills got=%0d required=0", kills); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spawn_seq();
    bus0.spawn_ready = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    set_stage(4'd1);
    run_until_empty(600, "spawn_seq");
    step();
    repeat (300) step();
    checks += 2;
    if (slot_active !== 2'b11) begin errors++; $display("FAIL seq_active got=%b required=11", slot_active); end
    if (kills !== 4'd0) begin errors++; $display("FAIL seq_kills got=%0d required=0", kills); end
  endtask

  task automatic test_double_kill();
    kill_hit = 2'b11;
    step();
    checks += 2;
    if (kills !== 4'd2) begin errors++; $display("FAIL dkill_kills got=%0d required=2", kills); end
    if (slot_active !== 2'b00) begin errors++; $display("FAIL dkill_active got=%b required=00", slot_active); end
    repeat (250) step();
  endtask

  task automatic test_stall();
    logic stable = 1'b1;
    bus0.spawn_ready = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    set_stage(4'd2);
    for (int n = 0; n < 400 && exp_q.size() == 2; n++) step();
    step();
    bus0.spawn_ready = 1'b0;
    run_until_empty(400, "stall");
    for (int n = 0; n < 10; n++) begin
      if (bus0.spawn_valid !== 1'b1 || bus0.spawn_slot !== 2'd1 ||
          bus0.spawn_lane !== last_exp_lane) stable = 1'b0;
      step();
    end
    checks += 2;
    if (!stable) begin errors++; $display("FAIL stall_stable got=changed required=held slot=1 lane=%0d", last_exp_lane); end
    if (slot_active !== 2'b01) begin errors++; $display("FAIL stall_active got=%b required=01", slot_active); end
    set_stage(4'hF);
    checks += 3;
    if (bus0.spawn_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b required=0", bus0.spawn_valid); end
    if (slot_active !== 2'b00) begin errors++; $display("FAIL abort_active got=%b required=00", slot_active); end
    if (kills !== 4'd2) begin errors++; $display("FAIL abort_kills got=%0d required=2", kills); end
  endtask

  task automatic test_full_game();
    int thr[5] = '{2, 4, 6, 8, 9};
    set_stage(4'd0);
    step();
    checks++;
    if (kills !== 4'd0) begin errors++; $display("FAIL game_start_kills got=%0d required=0", kills); end
    auto_kill = 1'b1;
    bus0.spawn_ready = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      play_stage(4'(s), (s == 5) ? 1 : 2, 250);
      checks++;
      if (kills !== 4'(thr[s-1])) begin
        errors++;
        $display("FAIL game_stage%0d_kills got=%0d required=%0d", s, kills, thr[s-1]);
      end
    end
    set_stage(4'hE);
    step();
    checks++;
    if (kills !== 4'd9) begin errors++; $display("FAIL win_kills got=%0d required=9", kills); end
    set_stage(4'd0);
    step();
    checks++;
    if (kills !== 4'd0) begin errors++; $display("FAIL title_kills got=%0d required=0", kills); end
  endtask

  task automatic test_saturate();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    set_stage(4'd1);
    kill_hit = 2'b10;
    step();
    checks += 2;
    if (kills !== 4'd0) begin errors++; $display("FAIL inactive_kill got=%0d required=0", kills); end
    if (slot_active !== 2'b00) begin errors++; $display("FAIL inactive_active got=%b required=00", slot_active); end
    run_until_empty(600, "sat_stage1");
    repeat (4) step();
    for (int s = 2; s <= 5; s++) play_stage(4'(s), (s == 5) ? 1 : 2, 4);
    for (int s = 1; s <= 4; s++) play_stage(4'(s), 2, 4);
    checks++;
    if (kills !== 4'd15) begin errors++; $display("FAIL kills_saturate got=%0d required=15", kills); end
    auto_kill = 1'b0;
  endtask

  task automatic test_busy();
    logic seen = 1'b0;
    logic early = 1'b0;
    bus1.spawn_ready = 1'b1;
    stage1 = 4'd2;
    for (int n = 0; n < 200 && !seen; n++) begin
      step();
      seen = bus1.spawn_valid;
    end
    step();
    checks += 2;
    if (!seen) begin errors++; $display("FAIL busy_first_spawn got=none required=request"); end
    if (slot_active1 !== 1'b1) begin errors++; $display("FAIL busy_active got=%b required=1", slot_active1); end
    for (int n = 0; n < 60; n++) begin
      step();
      if (bus1.spawn_valid) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL busy_no_request got=request required=none"); end
    kill_hit1 = 1'b1;
    step();
    checks += 3;
    if (bus1.spawn_valid !== 1'b0) begin errors++; $display("FAIL busy_kill_valid1 got=%b required=0", bus1.spawn_valid); end
    if (slot_active1 !== 1'b0) begin errors++; $display("FAIL busy_kill_active got=%b required=0", slot_active1); end
    if (kills1 !== 4'd1) begin errors++; $display("FAIL busy_kills got=%0d required=1", kills1); end
    step();
    checks++;
    if (bus1.spawn_valid !== 1'b1) begin errors++; $display("FAIL busy_kill_valid2 got=%b required=1", bus1.spawn_valid); end
  endtask

  task automatic test_async_reset();
    bus0.spawn_ready = 1'b0;
    exp_q.push_back(2'd0);
    set_stage(4'd1);
    run_until_empty(400, "async_req");
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (bus0.spawn_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b required=0", bus0.spawn_valid); end
    if (bus0.spawn_lane !== 3'd0) begin errors++; $display("FAIL arst_lane got=%0d required=0", bus0.spawn_lane); end
    if (kills !== 4'd0) begin errors++; $display("FAIL arst_kills got=%0d required=0", kills); end
    if (slot_active1 !== 1'b0 || kills1 !== 4'd0) begin
      errors++;
      $display("FAIL arst_dut1 active=%b kills=%0d required active=0 kills=0", slot_active1, kills1);
    end
    @(negedge clk);
    stage = 4'd0;
    stage1 = 4'd0;
    tb_stage_q = 4'd0;
    prev_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_spawn_seq();
    test_double_kill();
    test_stall();
    test_full_game();
    test_saturate();
    test_busy();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Sequences enemy spawns for each combat stage and owns the shared enemy slots. It also accumulates the kill count consumed by stage control. It sits between stage control (which supplies `stage`) and the enemy sprite/collision logic. That logic accepts spawn requests through a valid/ready handshake and reports per-slot kills.

## Interface
- `NUM_SLOTS`, 2: number of concurrently active enemy slots (1–4).
- `SPAWN_INTERVAL`, 50: frame ticks between spawn opportunities (1–255).
- `LFSR_SEED`, 8'hA5: reset value of the lane LFSR (must be nonzero).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `tick` in 1: one-cycle frame pulse.
- `stage` in 4: current stage (0 = title, 1–5 = combat, E = win, F = game over).
- `kill_hit` in NUM_SLOTS: per-slot kill pulse from collision logic.
- `spawn_ready` in 1: sprite logic accepts the spawn this cycle.
- `spawn_valid` out 1: spawn request.
- `spawn_slot` out 2: slot index of the request.
- `spawn_lane` out 3: lane for the new enemy.
- `slot_active` out NUM_SLOTS: occupied slots.
- `kills` out 4: cumulative kills this game.

## Operation
- Per-stage quota: stages 1–4 spawn 2 enemies each, stage 5 spawns 1. The resulting cumulative kill thresholds are 2, 4, 6, 8 and 9.
- States:
  - IDLE: stage not in 1–5.
  - WAIT: interval counting.
  - REQ: `spawn_valid` high.
  - DONE: quota spawned.
- Stage is registered internally as `stage_q`. Any cycle with `stage != stage_q` is a stage change, with the following effects:
  - all slots cleared;
  - `spawn_valid` dropped;
  - spawned-count cleared;
  - interval counter loaded with SPAWN_INTERVAL;
  - next state is WAIT if the new stage is 1–5, else IDLE.
- A stage change overrides every other event in that cycle, including a pending handshake and kills.
- WAIT behaviour:
  - Each `tick` decrements the interval counter, saturating at 0.
  - When counter = 0, spawned < quota and at least one slot is free, go to REQ.
  - REQ selects the lowest-index free slot and captures `lfsr[2:0]` into `spawn_lane`.
- REQ behaviour:
  - `spawn_valid`, `spawn_slot` and `spawn_lane` are held stable until `spawn_ready`.
  - On `spawn_valid && spawn_ready` the selected slot is set active, spawned increments, and the counter reloads to SPAWN_INTERVAL.
  - After the handshake, go to DONE if spawned = quota, else WAIT.
- Slot freeing:
  - A `kill_hit[i]` with `slot_active[i]` = 1 clears that slot and adds 1 to `kills`.
  - Kill pulses on inactive slots are ignored.
  - Simultaneous kills add their popcount.
  - `kills` saturates at 15.
- A kill on the slot being requested cannot occur, because that slot is still inactive. A kill on another slot during REQ does not change `spawn_slot`.
- `kills` is cleared while `stage` = 0 and holds its value in stages E and F.
- Lane LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock.
  - Reset value is LFSR_SEED.
- DONE stays in DONE until a stage change.

## Timing
- Reset values:
  - `spawn_valid` = 0, `spawn_slot` = 0, `spawn_lane` = 0, `slot_active` = 0, `kills` = 0.
  - State IDLE, `stage_q` = 0, counter = SPAWN_INTERVAL, LFSR = LFSR_SEED.
- Asserting `rst` mid-handshake drops `spawn_valid` immediately (asynchronously).
- First spawn latency: `spawn_valid` rises on the clock edge after the SPAWN_INTERVAL-th `tick` counted from the stage-change cycle.
- `spawn_valid` rises 1 cycle after the WAIT exit condition is met.
- A handshake takes effect on the edge where `spawn_valid && spawn_ready` holds: `slot_active` and the count update there and `spawn_valid` falls. Zero-wait `spawn_ready` therefore gives a one-cycle request.
- If all slots are busy at counter = 0, the block stays in WAIT with the counter held at 0. It enters REQ the cycle after the first slot frees.
- `kills` and `slot_active` update 1 cycle after `kill_hit`. `kill_hit` is sampled every clock and is independent of `tick`.
- Abort: a stage change during REQ drops `spawn_valid` the next cycle without a handshake. Sprite logic must tolerate valid falling without ready.

## Test plan
- Reset and enter stage 1, `spawn_ready` tied 1, `tick` every 4 clocks, SPAWN_INTERVAL = 50. Expect:
  - first `spawn_valid` for one cycle after tick 50, slot 0;
  - second spawn after a further 50 ticks, slot 1;
  - then DONE with no third request.
- Stage 1 with both slots active, then `kill_hit` = 2'b11 in one cycle. Expect `kills` 0→2 next cycle and `slot_active` 2'b00.
- NUM_SLOTS = 1, stage 2 with slot 0 still alive at counter = 0. Expect no `spawn_valid` until `kill_hit[0]`; then `spawn_valid` 2 cycles after the kill pulse.
- `spawn_ready` held 0 while `spawn_valid` is high, then stage 1→F. Expect:
  - `spawn_slot` and `spawn_lane` stable during the stall;
  - `spawn_valid` 0 the cycle after the change;
  - `slot_active` cleared and `kills` held.
- Full game stages 1–5 with every enemy killed immediately. Expect `kills` = 2, 4, 6, 8, 9 at the stage ends, and stage 5 issuing exactly 1 spawn. Then stage E→0, and expect `kills` = 0.
- `kill_hit` on an inactive slot, plus 16+ kills forced by test override. Expect the inactive-slot kill ignored and `kills` saturating at 15. Separately, assert `rst` low mid-REQ and expect all outputs 0 immediately.
